// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter family: FSM states, op codes, priority modes.
// Combinational-only package; no latency or flow control of its own.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter, fixed (lowest index) or round-robin; grant is combinational from req.
// Pointer moves to winner+1 only on accept, so an unaccepted grant never perturbs fairness.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int RR_EN = PRIO_RR
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req,
  input  logic                 accept,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  sel;

  // Requesters at or above the pointer go first; if none, wrap to the full vector.
  always_comb begin
    hi_mask = '0;
    for (int k = 0; k < N; k++) begin
      hi_mask[k] = (RR_EN == PRIO_RR) && (IW'(k) >= ptr_q);
    end
    sel = ((req & hi_mask) != '0) ? (req & hi_mask) : req;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (sel[k]) gnt_idx = IW'(k);
    end
    gnt_vld = |req;
    gnt     = gnt_vld ? (N'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter_multi.sv
// N-master read/write funnel onto one memory port; request->strobe 1 cycle, >=3 cycles/transaction.
// Masters hold requests until their one-cycle ready pulse; memory stalls via mem_ready_i.
module mem_arbiter_multi
  import mem_arb_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_EN     = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_MASTERS-1:0]          m_rd_i,
  input  logic [N_MASTERS-1:0]          m_wr_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_be_i,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
  input  logic                          mem_ready_i,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic                          mem_rd_o,
  output logic                          mem_wr_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic [DATA_W/8-1:0]           mem_be_o,
  output logic [N_MASTERS-1:0]          grant_o
);

  localparam int BE_W = DATA_W / 8;
  localparam int IW   = $clog2(N_MASTERS);

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;

  logic [1:0]           state_q;
  cmd_t                 cmd_q;
  cmd_t                 cmd_d;
  logic [IW-1:0]        own_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [DATA_W-1:0]    rdata_q [N_MASTERS];

  logic [ADDR_W-1:0]    addr_a  [N_MASTERS];
  logic [DATA_W-1:0]    wdata_a [N_MASTERS];
  logic [BE_W-1:0]      be_a    [N_MASTERS];

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;
  logic                 accept;

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_slice
    assign addr_a[k]  = m_addr_i[k*ADDR_W +: ADDR_W];
    assign wdata_a[k] = m_wdata_i[k*DATA_W +: DATA_W];
    assign be_a[k]    = m_be_i[k*BE_W +: BE_W];
    assign m_rdata_o[k*DATA_W +: DATA_W] = rdata_q[k];
  end

  assign req    = (m_rd_i | m_wr_i) & ~m_ready_o;
  assign accept = (state_q == ST_IDLE) && arb_vld;

  rr_arbiter #(
    .N     (N_MASTERS),
    .RR_EN (RR_EN)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req),
    .accept  (accept),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Write wins when a master raises both; reads always present full byte enables.
  always_comb begin
    cmd_d.op    = m_wr_i[arb_idx] ? OP_WR : OP_RD;
    cmd_d.addr  = addr_a[arb_idx];
    cmd_d.wdata = wdata_a[arb_idx];
    cmd_d.be    = m_wr_i[arb_idx] ? be_a[arb_idx] : '1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      for (int k = 0; k < N_MASTERS; k++) rdata_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_BUSY;
            cmd_q   <= cmd_d;
            own_q   <= arb_idx;
            grant_q <= arb_gnt;
          end
        end
        ST_BUSY: begin
          if (mem_ready_i) begin
            state_q <= ST_RESP;
            if (cmd_q.op == OP_RD) rdata_q[own_q] <= mem_rdata_i;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign m_ready_o   = (state_q == ST_RESP) ? grant_q : '0;
  assign mem_rd_o    = (state_q == ST_BUSY) && (cmd_q.op == OP_RD);
  assign mem_wr_o    = (state_q == ST_BUSY) && (cmd_q.op == OP_WR);
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign mem_be_o    = cmd_q.be;

endmodule

// File: tb/tb_mem_arbiter_multi.sv
// Directed bench for mem_arbiter_multi: cycle table plus mid-busy, reset and contention sequences.
module tb_mem_arbiter_multi;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      m_rd, m_wr;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*BW-1:0]   m_be;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;

  logic [N-1:0]      m_ready, m_ready_fx;
  logic [N*DW-1:0]   m_rdata, m_rdata_fx;
  logic              mem_rd, mem_rd_fx, mem_wr, mem_wr_fx;
  logic [AW-1:0]     mem_addr, mem_addr_fx;
  logic [DW-1:0]     mem_wdata, mem_wdata_fx;
  logic [BW-1:0]     mem_be, mem_be_fx;
  logic [N-1:0]      grant, grant_fx;

  mem_arbiter_multi #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .m_rd_i(m_rd), .m_wr_i(m_wr), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_be_i(m_be), .m_ready_o(m_ready), .m_rdata_o(m_rdata),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .grant_o(grant)
  );

  mem_arbiter_multi #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) dut_fx (
    .clk_i(clk), .rst_i(rst), .m_rd_i(m_rd), .m_wr_i(m_wr), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_be_i(m_be), .m_ready_o(m_ready_fx), .m_rdata_o(m_rdata_fx),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .mem_rd_o(mem_rd_fx), .mem_wr_o(mem_wr_fx),
    .mem_addr_o(mem_addr_fx), .mem_wdata_o(mem_wdata_fx), .mem_be_o(mem_be_fx), .grant_o(grant_fx)
  );

  typedef struct {
    logic [2:0]  rd, wr;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic [2:0]  e_gnt, e_rdy;
    logic [95:0] e_rdat;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [95:0] D0 = 96'h0;
  localparam logic [95:0] D1 = {32'h0, 32'hDEADBEEF, 32'h0};
  localparam logic [95:0] D2 = {32'h0, 32'hDEADBEEF, 32'h11111111};
  localparam logic [95:0] D3 = {32'h0, 32'hDEADBEEF, 32'h22222222};
  localparam logic [95:0] D4 = {32'h0, 32'h55AA55AA, 32'h22222222};

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] rd, input logic [2:0] wr, input logic rdy,
                     input logic [31:0] rdata, input logic e_rd, input logic e_wr,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata,
                     input logic [3:0] e_be, input logic [2:0] e_gnt,
                     input logic [2:0] e_rdy, input logic [95:0] e_rdat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rdy = rdy; v.rdata = rdata;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_be = e_be; v.e_gnt = e_gnt; v.e_rdy = e_rdy; v.e_rdat = e_rdat;
    vecs.push_back(v);
  endtask

  task automatic set_addr(input int k, input logic [31:0] a);
    m_addr[k*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] eg;

    // rd wr rdy rdata | mem_rd mem_wr addr wdata be grant ready rdata
    add(3'b010, 3'b000, 1, 32'hDEADBEEF, 0, 0, 32'h000, 32'h0,        4'h0, 3'b000, 3'b000, D0);
    add(3'b010, 3'b000, 1, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0,        4'hF, 3'b010, 3'b000, D0);
    add(3'b000, 3'b000, 0, 32'h0,        0, 0, 32'h100, 32'h0,        4'hF, 3'b010, 3'b010, D1);
    add(3'b100, 3'b100, 0, 32'h0,        0, 0, 32'h100, 32'h0,        4'hF, 3'b000, 3'b000, D1);
    add(3'b100, 3'b100, 0, 32'h0,        0, 1, 32'h080, 32'h12345678, 4'h3, 3'b100, 3'b000, D1);
    add(3'b100, 3'b100, 0, 32'h0,        0, 1, 32'h080, 32'h12345678, 4'h3, 3'b100, 3'b000, D1);
    add(3'b100, 3'b100, 0, 32'h0,        0, 1, 32'h080, 32'h12345678, 4'h3, 3'b100, 3'b000, D1);
    add(3'b100, 3'b100, 1, 32'hCAFEF00D, 0, 1, 32'h080, 32'h12345678, 4'h3, 3'b100, 3'b000, D1);
    add(3'b000, 3'b000, 0, 32'h0,        0, 0, 32'h080, 32'h12345678, 4'h3, 3'b100, 3'b100, D1);
    add(3'b001, 3'b000, 1, 32'h11111111, 0, 0, 32'h080, 32'h12345678, 4'h3, 3'b000, 3'b000, D1);
    add(3'b001, 3'b000, 1, 32'h11111111, 1, 0, 32'h040, 32'h0,        4'hF, 3'b001, 3'b000, D1);
    add(3'b001, 3'b000, 1, 32'h22222222, 0, 0, 32'h040, 32'h0,        4'hF, 3'b001, 3'b001, D2);
    add(3'b001, 3'b000, 1, 32'h22222222, 0, 0, 32'h040, 32'h0,        4'hF, 3'b000, 3'b000, D2);
    add(3'b001, 3'b000, 1, 32'h22222222, 1, 0, 32'h040, 32'h0,        4'hF, 3'b001, 3'b000, D2);
    add(3'b000, 3'b000, 0, 32'h0,        0, 0, 32'h040, 32'h0,        4'hF, 3'b001, 3'b001, D3);
    add(3'b000, 3'b000, 0, 32'h0,        0, 0, 32'h040, 32'h0,        4'hF, 3'b000, 3'b000, D3);

    rst = 1'b1; m_rd = '0; m_wr = '0; mem_ready = 1'b0; mem_rdata = '0;
    m_addr = '0; m_wdata = '0; m_be = '0;
    set_addr(0, 32'h40); set_addr(1, 32'h100); set_addr(2, 32'h80);
    m_wdata[2*DW +: DW] = 32'h12345678;
    m_be[2*BW +: BW]    = 4'b0011;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      m_rd = vecs[i].rd; m_wr = vecs[i].wr;
      mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("row%0d mem_rd", i),    mem_rd,    vecs[i].e_rd);
      chk($sformatf("row%0d mem_wr", i),    mem_wr,    vecs[i].e_wr);
      chk($sformatf("row%0d mem_addr", i),  mem_addr,  vecs[i].e_addr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("row%0d mem_be", i),    mem_be,    vecs[i].e_be);
      chk($sformatf("row%0d grant", i),     grant,     vecs[i].e_gnt);
      chk($sformatf("row%0d m_ready", i),   m_ready,   vecs[i].e_rdy);
      chk($sformatf("row%0d m_rdata", i),   m_rdata,   vecs[i].e_rdat);
      @(negedge clk);
    end

    // Master 1 moves its address while the memory stalls; the latched 0x200 must stay.
    m_rd = 3'b010; set_addr(1, 32'h200); mem_ready = 1'b0;
    #1; chk("midbusy idle grant", grant, 3'b000);
    @(negedge clk);
    set_addr(1, 32'h300);
    #1; chk("midbusy addr c1", mem_addr, 32'h200);
    chk("midbusy rd c1", mem_rd, 1'b1);
    chk("midbusy grant c1", grant, 3'b010);
    @(negedge clk);
    #1; chk("midbusy addr c2", mem_addr, 32'h200);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
    #1; chk("midbusy addr c3", mem_addr, 32'h200);
    chk("midbusy rd c3", mem_rd, 1'b1);
    @(negedge clk);
    m_rd = 3'b000; mem_ready = 1'b0;
    #1; chk("midbusy ready", m_ready, 3'b010);
    chk("midbusy addr resp", mem_addr, 32'h200);
    chk("midbusy rdata", m_rdata, D4);
    @(negedge clk);

    // Reset lands while master 1 is in BUSY (RR pointer is at 2 at this point).
    m_rd = 3'b010;
    #1; chk("rst pre ready", m_ready, 3'b000);
    @(negedge clk);
    #1; chk("rst busy rd", mem_rd, 1'b1);
    chk("rst busy grant", grant, 3'b010);
    rst = 1'b1; m_rd = 3'b000;
    @(negedge clk);
    rst = 1'b0; m_rd = 3'b111; mem_ready = 1'b1; mem_rdata = 32'h77;
    set_addr(1, 32'h300);
    #1;
    chk("rst mem_rd", mem_rd, 1'b0);
    chk("rst mem_wr", mem_wr, 1'b0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_be", mem_be, 4'h0);
    chk("rst grant", grant, 3'b000);
    chk("rst m_ready", m_ready, 3'b000);
    chk("rst m_rdata", m_rdata, D0);
    chk("rst fx grant", grant_fx, 3'b000);
    chk("rst fx m_rdata", m_rdata_fx, D0);
    @(negedge clk);

    // All three hold reads: RR rotates from master 0, fixed always picks master 0.
    for (int t = 0; t < 6; t++) begin
      eg = 3'b001 << (t % 3);
      #1;
      chk($sformatf("cont%0d rr grant", t), grant, eg);
      chk($sformatf("cont%0d fx grant", t), grant_fx, 3'b001);
      chk($sformatf("cont%0d busy ready", t), m_ready, 3'b000);
      @(negedge clk);
      #1;
      chk($sformatf("cont%0d rr ready", t), m_ready, eg);
      chk($sformatf("cont%0d fx ready", t), m_ready_fx, 3'b001);
      @(negedge clk);
      #1;
      chk($sformatf("cont%0d idle grant", t), grant, 3'b000);
      @(negedge clk);
    end

    m_rd = '0; mem_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
